relogio_contador: RTL and testbench
===================================

# relogio_contador

Timekeeping core of the digital clock. It consumes the one-clock-wide 1 Hz enable pulse produced by the tick generator and keeps hours/minutes/seconds in BCD for the display path. It provides a button-driven set mode for hours and minutes, and a day-rollover pulse.

## Interface
- RESET_H, 0: hour loaded on reset, binary 0–23.
- RESET_M, 0: minute loaded on reset, binary 0–59.
- relogio_clock  in  1  system clock (50 MHz).
- relogio_reset  in  1  synchronous, active-high reset.
- relogio_tick  in  1  1 Hz enable; high for exactly one relogio_clock cycle per second.
- relogio_btn_mode  in  1  mode button; already debounced and synchronous to relogio_clock, level.
- relogio_btn_inc  in  1  increment button; same conditioning as relogio_btn_mode.
- relogio_h_dez  out  2  hours tens, BCD 0–2.
- relogio_h_uni  out  4  hours units, BCD 0–9.
- relogio_m_dez  out  3  minutes tens, BCD 0–5.
- relogio_m_uni  out  4  minutes units, BCD 0–9.
- relogio_s_dez  out  3  seconds tens, BCD 0–5.
- relogio_s_uni  out  4  seconds units, BCD 0–9.
- relogio_modo  out  2  current state: 00 RUN, 01 SET_HORA, 10 SET_MIN. Value 11 is never driven.
- relogio_virada  out  1  one-cycle pulse on wrap from 23:59:59 to 00:00:00.

## Operation
- All outputs are registered.
- Reset values:
  - Time is RESET_H:RESET_M:00 in BCD.
  - relogio_modo = 00.
  - relogio_virada = 0.
  - Both button-history registers are set to 1.
- Button events are rising edges only: current = 1 and previous = 0. A button held through reset produces no event until it is released and pressed again.
- State machine, advanced by a mode event: RUN → SET_HORA → SET_MIN → RUN.
- RUN:
  - A tick increments seconds.
  - Seconds carry 59 → 00 into minutes; minutes carry 59 → 00 into hours; hours wrap 23 → 00.
  - Units digits wrap 9 → 0 with carry into tens.
  - Hours wrap at the combined value 23, not when units reach 9 with tens = 2.
- SET_HORA:
  - Entering this state clears seconds to 00.
  - A relogio_btn_inc event increments hours modulo 24, with no effect on minutes.
  - Ticks are ignored.
- SET_MIN:
  - A relogio_btn_inc event increments minutes modulo 60, with no carry into hours.
  - Ticks are ignored.
  - Seconds stay 00.
- Return to RUN: counting resumes from HH:MM:00 on the next tick.
- relogio_virada is asserted only by a RUN tick that wraps 23:59:59. Hour wrap 23 → 00 in SET_HORA does not assert it.
- Simultaneous events:
  - Mode event and inc event in the same cycle: the mode event wins and the inc event is discarded.
  - Mode event and tick in the same cycle while in RUN: the transition to SET_HORA wins, the tick is discarded, and seconds clear.
  - Tick and inc event in a SET state: the inc event applies and the tick is dropped.
- Reset asserted mid-operation, in any state or mid-carry, overrides everything on that edge.

## Timing
- Latency: an input (tick or button edge) sampled high at edge N produces updated outputs after edge N. They are visible during cycle N+1.
- relogio_virada is high for exactly the cycle after the wrapping tick edge, concurrent with the time reading 00:00:00.
- Ticks must be one cycle wide. A tick held high for k cycles counts k seconds; that is the producer's responsibility, not checked.
- Button edge detection costs one register stage. Detection occurs on the first edge at which the button is seen high.
- No combinational path from any input to any output.

## Test plan
- Reset with RESET_H=12, RESET_M=34 → outputs read 12:34:00, relogio_modo=00, relogio_virada=0, starting the cycle after reset.
- Load 23:59:58 (reset with RESET_H=23, RESET_M=59, then 58 ticks) and apply 2 ticks → 23:59:59, then 00:00:00 with relogio_virada high for exactly one cycle.
- From 09:59:59 in RUN apply 1 tick → 10:00:00. From 19:59:59 apply 1 tick → 20:00:00. No relogio_virada in either case.
- Sequence:
  - At 08:15:42, a mode press → SET_HORA, 08:15:00.
  - 17 inc presses → 01:15:00; the wrap through 23 gives no relogio_virada.
  - A mode press → SET_MIN.
  - 50 inc presses → 01:05:00; no carry into hours.
  - A mode press → RUN; the next tick gives 01:05:01.
- Ticks every 5 cycles during SET_MIN for 100 cycles → time unchanged.
- Corner cases:
  - Button held high through reset release → no state change.
  - Mode and inc asserted together → state advances and time is unchanged.
  - Reset pulsed in SET_MIN → 00:00:00 in RUN with defaults.

Source files
------------

// File: rtl/relogio_contador.sv
// rtl/relogio_contador.sv - BCD hh:mm:ss timekeeper with button set mode and day-rollover pulse
module relogio_contador #(
   parameter int RESET_H = 0,
   parameter int RESET_M = 0
) (
   input  logic       relogio_clock,
   input  logic       relogio_reset,
   input  logic       relogio_tick,
   input  logic       relogio_btn_mode,
   input  logic       relogio_btn_inc,
   output logic [1:0] relogio_h_dez,
   output logic [3:0] relogio_h_uni,
   output logic [2:0] relogio_m_dez,
   output logic [3:0] relogio_m_uni,
   output logic [2:0] relogio_s_dez,
   output logic [3:0] relogio_s_uni,
   output logic [1:0] relogio_modo,
   output logic       relogio_virada
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HORA = 2'b01,
      SET_MIN  = 2'b10
   } estado_t;

   localparam logic [1:0] RST_H_DEZ = 2'(RESET_H / 10);
   localparam logic [3:0] RST_H_UNI = 4'(RESET_H % 10);
   localparam logic [2:0] RST_M_DEZ = 3'(RESET_M / 10);
   localparam logic [3:0] RST_M_UNI = 4'(RESET_M % 10);

   estado_t    estado;
   logic       mode_prev;
   logic       inc_prev;
   logic       mode_evt;
   logic       inc_evt;
   logic       min_last;
   logic       hora_last;
   logic [1:0] h_dez_nxt;
   logic [3:0] h_uni_nxt;
   logic [2:0] m_dez_nxt;
   logic [3:0] m_uni_nxt;

   assign relogio_modo = estado;

   // Next hour/minute values are shared by the RUN carry chain and the set-mode increments.
   always_comb begin
      mode_evt  = relogio_btn_mode & ~mode_prev;
      inc_evt   = relogio_btn_inc & ~inc_prev;
      min_last  = (relogio_m_dez == 3'd5) && (relogio_m_uni == 4'd9);
      hora_last = (relogio_h_dez == 2'd2) && (relogio_h_uni == 4'd3);

      h_dez_nxt = relogio_h_dez;
      h_uni_nxt = relogio_h_uni + 4'd1;
      if (hora_last) begin
         h_dez_nxt = 2'd0;
         h_uni_nxt = 4'd0;
      end else if (relogio_h_uni == 4'd9) begin
         h_dez_nxt = relogio_h_dez + 2'd1;
         h_uni_nxt = 4'd0;
      end

      m_dez_nxt = relogio_m_dez;
      m_uni_nxt = relogio_m_uni + 4'd1;
      if (min_last) begin
         m_dez_nxt = 3'd0;
         m_uni_nxt = 4'd0;
      end else if (relogio_m_uni == 4'd9) begin
         m_dez_nxt = relogio_m_dez + 3'd1;
         m_uni_nxt = 4'd0;
      end
   end

   always_ff @(posedge relogio_clock) begin
      if (relogio_reset) begin
         relogio_h_dez  <= RST_H_DEZ;
         relogio_h_uni  <= RST_H_UNI;
         relogio_m_dez  <= RST_M_DEZ;
         relogio_m_uni  <= RST_M_UNI;
         relogio_s_dez  <= 3'd0;
         relogio_s_uni  <= 4'd0;
         estado         <= RUN;
         relogio_virada <= 1'b0;
         // History starts high so a button held through reset is not seen as a press.
         mode_prev      <= 1'b1;
         inc_prev       <= 1'b1;
      end else begin
         mode_prev      <= relogio_btn_mode;
         inc_prev       <= relogio_btn_inc;
         relogio_virada <= 1'b0;
         if (mode_evt) begin
            case (estado)
               RUN: begin
                  estado        <= SET_HORA;
                  relogio_s_dez <= 3'd0;
                  relogio_s_uni <= 4'd0;
               end
               SET_HORA: estado <= SET_MIN;
               default:  estado <= RUN;
            endcase
         end else begin
            case (estado)
               RUN: begin
                  if (relogio_tick) begin
                     if (relogio_s_uni != 4'd9) begin
                        relogio_s_uni <= relogio_s_uni + 4'd1;
                     end else begin
                        relogio_s_uni <= 4'd0;
                        if (relogio_s_dez != 3'd5) begin
                           relogio_s_dez <= relogio_s_dez + 3'd1;
                        end else begin
                           relogio_s_dez <= 3'd0;
                           relogio_m_dez <= m_dez_nxt;
                           relogio_m_uni <= m_uni_nxt;
                           if (min_last) begin
                              relogio_h_dez <= h_dez_nxt;
                              relogio_h_uni <= h_uni_nxt;
                              if (hora_last) relogio_virada <= 1'b1;
                           end
                        end
                     end
                  end
               end
               SET_HORA: begin
                  if (inc_evt) begin
                     relogio_h_dez <= h_dez_nxt;
                     relogio_h_uni <= h_uni_nxt;
                  end
               end
               SET_MIN: begin
                  if (inc_evt) begin
                     relogio_m_dez <= m_dez_nxt;
                     relogio_m_uni <= m_uni_nxt;
                  end
               end
               default: estado <= RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_relogio_contador.sv
// tb/tb_relogio_contador.sv - scoreboard bench for relogio_contador on three parameterisations
module tb_relogio_contador;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_v [3];
   logic       tk_v  [3];
   logic       bm_v  [3];
   logic       bi_v  [3];
   logic [1:0] h_dez [3];
   logic [3:0] h_uni [3];
   logic [2:0] m_dez [3];
   logic [3:0] m_uni [3];
   logic [2:0] s_dez [3];
   logic [3:0] s_uni [3];
   logic [1:0] modo  [3];
   logic       virada[3];
   logic [22:0] obs  [3];

   relogio_contador #(.RESET_H(12), .RESET_M(34)) u_a (
      .relogio_clock(clk), .relogio_reset(rst_v[0]), .relogio_tick(tk_v[0]),
      .relogio_btn_mode(bm_v[0]), .relogio_btn_inc(bi_v[0]),
      .relogio_h_dez(h_dez[0]), .relogio_h_uni(h_uni[0]), .relogio_m_dez(m_dez[0]),
      .relogio_m_uni(m_uni[0]), .relogio_s_dez(s_dez[0]), .relogio_s_uni(s_uni[0]),
      .relogio_modo(modo[0]), .relogio_virada(virada[0]));

   relogio_contador #(.RESET_H(23), .RESET_M(59)) u_b (
      .relogio_clock(clk), .relogio_reset(rst_v[1]), .relogio_tick(tk_v[1]),
      .relogio_btn_mode(bm_v[1]), .relogio_btn_inc(bi_v[1]),
      .relogio_h_dez(h_dez[1]), .relogio_h_uni(h_uni[1]), .relogio_m_dez(m_dez[1]),
      .relogio_m_uni(m_uni[1]), .relogio_s_dez(s_dez[1]), .relogio_s_uni(s_uni[1]),
      .relogio_modo(modo[1]), .relogio_virada(virada[1]));

   relogio_contador u_c (
      .relogio_clock(clk), .relogio_reset(rst_v[2]), .relogio_tick(tk_v[2]),
      .relogio_btn_mode(bm_v[2]), .relogio_btn_inc(bi_v[2]),
      .relogio_h_dez(h_dez[2]), .relogio_h_uni(h_uni[2]), .relogio_m_dez(m_dez[2]),
      .relogio_m_uni(m_uni[2]), .relogio_s_dez(s_dez[2]), .relogio_s_uni(s_uni[2]),
      .relogio_modo(modo[2]), .relogio_virada(virada[2]));

   for (genvar g = 0; g < 3; g++) begin : g_obs
      assign obs[g] = {h_dez[g], h_uni[g], m_dez[g], m_uni[g], s_dez[g], s_uni[g], modo[g], virada[g]};
   end

   typedef struct {
      int          cyc;
      int          idx;
      logic [22:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   last_cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   // Integer reference time per instance, advanced one clock at a time.
   int rh [3] = '{12, 23, 0};
   int rm [3] = '{34, 59, 0};
   int mh [3];
   int mm [3];
   int ms [3];
   int mmd[3];
   int mv [3];
   bit mpm[3];
   bit mpi[3];

   function automatic logic [22:0] pack(int h, int m, int s, int md, int v);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), 2'(md), 1'(v)};
   endfunction

   function automatic string fmt(logic [22:0] v);
      return $sformatf("%0d%0d:%0d%0d:%0d%0d modo=%0d virada=%0d",
                       v[22:21], v[20:17], v[16:14], v[13:10], v[9:7], v[6:3], v[2:1], v[0]);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         n_checks++;
         if (e.cyc != cyc) begin
            n_errors++;
            $display("FAIL %s dut%0d: expectation for cycle %0d left unchecked at cycle %0d",
                     e.name, e.idx, e.cyc, cyc);
         end else if (obs[e.idx] !== e.val) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc %0d: got %s, required %s",
                     e.name, e.idx, cyc, fmt(obs[e.idx]), fmt(e.val));
         end
      end
   end

   // idx 3 drives every instance; otherwise only idx gets the inputs and the others idle.
   task automatic step(int idx, bit r, bit t, bit bm, bit bi);
      bit on, rv, tv, bmv, biv, me, ie;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         on  = (idx == 3) || (idx == k);
         rv  = on & r;
         tv  = on & t;
         bmv = on & bm;
         biv = on & bi;
         rst_v[k] = rv;
         tk_v[k]  = tv;
         bm_v[k]  = bmv;
         bi_v[k]  = biv;
         if (rv) begin
            mh[k] = rh[k]; mm[k] = rm[k]; ms[k] = 0; mmd[k] = 0; mv[k] = 0;
            mpm[k] = 1'b1; mpi[k] = 1'b1;
         end else begin
            me = bmv && !mpm[k];
            ie = biv && !mpi[k];
            mpm[k] = bmv;
            mpi[k] = biv;
            mv[k] = 0;
            if (me) begin
               mmd[k] = (mmd[k] + 1) % 3;
               if (mmd[k] == 1) ms[k] = 0;
            end else if (mmd[k] == 0) begin
               if (tv) begin
                  ms[k]++;
                  if (ms[k] == 60) begin
                     ms[k] = 0; mm[k]++;
                     if (mm[k] == 60) begin
                        mm[k] = 0; mh[k]++;
                        if (mh[k] == 24) begin mh[k] = 0; mv[k] = 1; end
                     end
                  end
               end
            end else if (mmd[k] == 1) begin
               if (ie) mh[k] = (mh[k] + 1) % 24;
            end else begin
               if (ie) mm[k] = (mm[k] + 1) % 60;
            end
         end
         q.push_back('{cyc + 1, k, pack(mh[k], mm[k], ms[k], mmd[k], mv[k]), "model"});
      end
      last_cyc = cyc + 1;
   endtask

   task automatic hand(int idx, int h, int m, int s, int md, int v, string name);
      q.push_back('{last_cyc, idx, pack(h, m, s, md, v), name});
   endtask

   task automatic press_mode(int idx);
      step(idx, 0, 0, 1, 0);
      step(idx, 0, 0, 0, 0);
   endtask

   task automatic press_inc(int idx);
      step(idx, 0, 0, 0, 1);
      step(idx, 0, 0, 0, 0);
   endtask

   task automatic ticks(int idx, int n);
      repeat (n) step(idx, 0, 1, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_v[k] = 1'b0; tk_v[k] = 1'b0; bm_v[k] = 1'b0; bi_v[k] = 1'b0;
      end

      step(3, 1, 0, 0, 0);
      step(3, 1, 0, 0, 0);
      hand(0, 12, 34, 0, 0, 0, "reset_a");
      hand(1, 23, 59, 0, 0, 0, "reset_b");
      hand(2, 0, 0, 0, 0, 0, "reset_c");
      step(3, 0, 0, 0, 0);
      hand(0, 12, 34, 0, 0, 0, "after_reset_a");

      ticks(1, 58);  hand(1, 23, 59, 58, 0, 0, "b_235958");
      ticks(1, 1);   hand(1, 23, 59, 59, 0, 0, "b_235959");
      ticks(1, 1);   hand(1, 0, 0, 0, 0, 1, "day_wrap_virada");
      step(1, 0, 0, 0, 0);
      hand(1, 0, 0, 0, 0, 0, "virada_one_cycle");

      press_mode(2); repeat (9) press_inc(2);
      press_mode(2); repeat (59) press_inc(2);
      press_mode(2); ticks(2, 59);
      hand(2, 9, 59, 59, 0, 0, "c_095959");
      ticks(2, 1);   hand(2, 10, 0, 0, 0, 0, "carry_to_10");
      press_mode(2); repeat (9) press_inc(2);
      press_mode(2); repeat (59) press_inc(2);
      press_mode(2); ticks(2, 59);
      hand(2, 19, 59, 59, 0, 0, "c_195959");
      ticks(2, 1);   hand(2, 20, 0, 0, 0, 0, "carry_to_20");

      press_mode(0); repeat (20) press_inc(0);
      press_mode(0); repeat (41) press_inc(0);
      press_mode(0); ticks(0, 42);
      hand(0, 8, 15, 42, 0, 0, "a_081542");
      press_mode(0);             hand(0, 8, 15, 0, 1, 0, "enter_set_hora");
      repeat (17) press_inc(0);  hand(0, 1, 15, 0, 1, 0, "hour_wrap_in_set");
      press_mode(0);             hand(0, 1, 15, 0, 2, 0, "enter_set_min");
      repeat (50) press_inc(0);  hand(0, 1, 5, 0, 2, 0, "min_wrap_no_carry");
      for (int i = 0; i < 100; i++) step(0, 0, (i % 5) == 0, 0, 0);
      hand(0, 1, 5, 0, 2, 0, "ticks_ignored_set_min");
      press_mode(0);             hand(0, 1, 5, 0, 0, 0, "back_to_run");
      ticks(0, 1);               hand(0, 1, 5, 1, 0, 0, "resume_counting");

      step(2, 1, 0, 1, 1);       hand(2, 0, 0, 0, 0, 0, "reset_buttons_held");
      repeat (3) step(2, 0, 0, 1, 1);
      hand(2, 0, 0, 0, 0, 0, "held_buttons_no_event");
      step(2, 0, 0, 0, 0);
      ticks(2, 3);               hand(2, 0, 0, 3, 0, 0, "c_000003");
      step(2, 0, 1, 1, 0);       hand(2, 0, 0, 0, 1, 0, "mode_beats_tick");
      step(2, 0, 0, 0, 0);
      press_inc(2);              hand(2, 1, 0, 0, 1, 0, "inc_hour");
      step(2, 0, 1, 0, 1);       hand(2, 2, 0, 0, 1, 0, "inc_beats_tick");
      step(2, 0, 0, 0, 0);
      step(2, 0, 0, 1, 1);       hand(2, 2, 0, 0, 2, 0, "mode_beats_inc");
      step(2, 0, 0, 0, 0);
      press_inc(2);              hand(2, 2, 1, 0, 2, 0, "inc_minute");
      step(2, 1, 0, 0, 0);       hand(2, 0, 0, 0, 0, 0, "reset_in_set_min");
      step(2, 0, 0, 0, 0);       hand(2, 0, 0, 0, 0, 0, "after_reset_c");

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
